// File: rtl/hdmi_pixel_fifo.sv
// hdmi_pixel_fifo
// ---------------
// Pixel buffer sitting directly in front of the HDMI timing/TMDS stage, in
// the clock_pixel domain. A frame loader pushes 24-bit RGB words (tagged with
// a start-of-frame bit) into a DEPTH-entry FIFO. The HDMI stage consumes one
// pixel per cycle while DE is high. The buffer also:
// - requests refills below a low-water mark;
// - substitutes a fixed colour when a pixel is demanded but none is ready,
//   and counts those pixels;
// - realigns to the start-of-frame word at every vertical sync.
//
// Ports
//   clock_pixel, reset_n       : pixel clock, async active-low reset
//   wr_valid/wr_ready/wr_data/wr_sof : loader write channel
//   DE, SYNC_V                 : active-video strobe, vsync (active low)
//   clear_status               : pulse, clears underflow flag and counter
//   oRed/oGreen/oBlue          : pixel for the current cycle
//   fill_level                 : accepted words not yet consumed
//   need_data                  : fill_level < LOW_WATER
//   underflow, underflow_cnt   : sticky flag, saturating 16-bit count
//   resyncing                  : FSM state debug, high in RESYNC
//
// Handshake: a word transfers on a rising edge where wr_valid && wr_ready.
// wr_ready depends only on the registered fill level, never on wr_valid.
// The loader holds wr_data/wr_sof stable while wr_valid is high and not
// yet accepted.

module hdmi_pixel_fifo #(
  parameter int          ADDR_W        = 10,
  parameter int          LOW_WATER     = 256,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic              clock_pixel,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [23:0]       wr_data,
  input  logic              wr_sof,
  input  logic              DE,
  input  logic              SYNC_V,
  input  logic              clear_status,
  output logic [7:0]        oRed,
  output logic [7:0]        oGreen,
  output logic [7:0]        oBlue,
  output logic [ADDR_W:0]   fill_level,
  output logic              need_data,
  output logic              underflow,
  output logic [15:0]       underflow_cnt,
  output logic              resyncing
);

  localparam int             DEPTH       = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LOW_WATER_L = (ADDR_W+1)'(LOW_WATER);
  localparam logic [ADDR_W:0] PTR_ONE     = (ADDR_W+1)'(1);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_RESYNC = 1'b1
  } state_t;

  // Storage: {sof, rgb}. No reset, so it maps onto block RAM.
  logic [24:0] mem [DEPTH];
  // Head word: registered read of mem, valid one edge after the write.
  logic [24:0] head_word_q;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   fill_level_q, fill_level_d;
  logic              head_valid_q, head_valid_d;
  logic              sync_v_prev_q, sync_v_prev_d;
  logic              underflow_q, underflow_d;
  logic [15:0]       underflow_cnt_q, underflow_cnt_d;

  logic              accept;
  logic              pop;
  logic              load_head;
  logic              mem_empty;
  logic              vsync_fall;
  logic              head_sof;
  logic              underflow_evt;
  logic              show_head;

  assign wr_ready   = (fill_level_q < DEPTH_L);
  assign accept     = wr_valid && wr_ready;
  assign mem_empty  = (wr_ptr_q == rd_ptr_q);
  assign vsync_fall = sync_v_prev_q && !SYNC_V;
  assign head_sof   = head_word_q[24];

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    underflow_evt = 1'b0;
    case (state_q)
      ST_RUN: begin
        pop           = DE && head_valid_q;
        underflow_evt = DE && !head_valid_q;
        if (vsync_fall && !(head_valid_q && head_sof)) begin
          state_d = ST_RESYNC;
          // A non-sof head is stale at vsync; drop it on the way in.
          if (head_valid_q) pop = 1'b1;
        end
      end
      ST_RESYNC: begin
        // The display gets the substitute colour for the whole realignment.
        underflow_evt = DE;
        if (head_valid_q) begin
          if (head_sof) state_d = ST_RUN;
          else          pop     = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Prefetch into the head register whenever it is free or being vacated.
  assign load_head = !mem_empty && (!head_valid_q || pop);

  always_comb begin
    wr_ptr_d        = accept    ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d        = load_head ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    head_valid_d    = load_head ? 1'b1 : (pop ? 1'b0 : head_valid_q);
    sync_v_prev_d   = SYNC_V;

    fill_level_d = fill_level_q;
    case ({accept, pop})
      2'b10:   fill_level_d = fill_level_q + PTR_ONE;
      2'b01:   fill_level_d = fill_level_q - PTR_ONE;
      default: fill_level_d = fill_level_q;
    endcase

    // clear_status wins over an underflow in the same cycle.
    underflow_d     = underflow_q;
    underflow_cnt_d = underflow_cnt_q;
    if (clear_status) begin
      underflow_d     = 1'b0;
      underflow_cnt_d = 16'd0;
    end else if (underflow_evt) begin
      underflow_d = 1'b1;
      if (underflow_cnt_q != 16'hFFFF) underflow_cnt_d = underflow_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_RUN;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fill_level_q    <= '0;
      head_valid_q    <= 1'b0;
      sync_v_prev_q   <= 1'b1;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= 16'd0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fill_level_q    <= fill_level_d;
      head_valid_q    <= head_valid_d;
      sync_v_prev_q   <= sync_v_prev_d;
      underflow_q     <= underflow_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  always_ff @(posedge clock_pixel) begin
    if (accept) mem[wr_ptr_q[ADDR_W-1:0]] <= {wr_sof, wr_data};
  end

  always_ff @(posedge clock_pixel) begin
    if (load_head) head_word_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  // In RESYNC with DE high the display must see the substitute colour even
  // though a (to-be-discarded) head word may be present.
  assign show_head = head_valid_q && !(state_q == ST_RESYNC && DE);

  always_comb begin
    oRed   = UNDERFLOW_RGB[23:16];
    oGreen = UNDERFLOW_RGB[15:8];
    oBlue  = UNDERFLOW_RGB[7:0];
    if (show_head) begin
      oRed   = head_word_q[23:16];
      oGreen = head_word_q[15:8];
      oBlue  = head_word_q[7:0];
    end
  end

  assign fill_level    = fill_level_q;
  assign need_data     = (fill_level_q < LOW_WATER_L);
  assign underflow     = underflow_q;
  assign underflow_cnt = underflow_cnt_q;
  assign resyncing     = (state_q == ST_RESYNC);

endmodule
